// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters driving the select of a downstream 4:1 mux.
// Optional beat limit per grant is enabled with the ARB_MAX_BEATS_EN macro.
module mux4_rr_arbiter #(
  parameter int MAX_BEATS = 8,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ready,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;

  if (MAX_BEATS >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("CNT_W too narrow to hold MAX_BEATS");
  end

  // Returns {found, index} of the first set bit scanning p, p+1, ... modulo 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      c = p + 2'(k);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  logic [3:0] others;
  logic [1:0] next_ptr;
  logic [2:0] idle_pick;
  logic [2:0] rel_pick;
  logic       release_now;

  assign others    = req & ~(4'b0001 << sel);
  assign next_ptr  = sel + 2'd1;
  assign idle_pick = pick(req, ptr);
  // The releasing channel is masked out even if it re-asserts this cycle.
  assign rel_pick  = pick(others, next_ptr);

`ifdef ARB_MAX_BEATS_EN
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] cnt_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    if (inc && (cnt < MAX_CNT)) return cnt + 1'b1;
    return cnt;
  endfunction

  assign cnt_next    = sat_inc(beat_cnt, valid && ready);
  // A forced release only happens when someone else is waiting for the mux.
  assign release_now = !req[sel] || ((cnt_next == MAX_CNT) && (|others));
`else
  logic unused_ready;
  assign unused_ready = ready;
  assign release_now  = !req[sel];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'b00;
      valid <= 1'b0;
      ptr   <= 2'd0;
`ifdef ARB_MAX_BEATS_EN
      beat_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (idle_pick[2]) begin
            state <= GRANT;
            valid <= 1'b1;
            sel   <= idle_pick[1:0];
            gnt   <= 4'b0001 << idle_pick[1:0];
`ifdef ARB_MAX_BEATS_EN
            beat_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr <= next_ptr;
`ifdef ARB_MAX_BEATS_EN
            beat_cnt <= '0;
`endif
            if (rel_pick[2]) begin
              sel <= rel_pick[1:0];
              gnt <= 4'b0001 << rel_pick[1:0];
            end else begin
              state <= IDLE;
              valid <= 1'b0;
              gnt   <= 4'b0000;
            end
          end else begin
`ifdef ARB_MAX_BEATS_EN
            beat_cnt <= cnt_next;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural ownership model.
module tb_mux4_rr_arbiter;

  localparam int MAXB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       ready = 1'b0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the mux, rotating priority, beats in this grant.
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_beats = 0;
  logic [1:0] m_sel   = 2'b00;

  mux4_rr_arbiter #(.MAX_BEATS(MAXB), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .ready (ready),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_gnt();
    if (m_owner < 0) return 4'b0000;
    return 4'b0001 << m_owner;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] q, input logic rd);
    int  old;
    int  c;
    bit  rel;
    bit  others;
    bit  found;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_beats = 0; m_sel = 2'b00;
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (!found && q[c]) begin
          found = 1; m_owner = c; m_sel = 2'(c); m_beats = 0;
        end
      end
    end else begin
      old    = m_owner;
      rel    = !q[old];
      others = (q & ~(4'b0001 << old)) != 4'b0000;
`ifdef ARB_MAX_BEATS_EN
      if (rd) m_beats = (m_beats + 1 > MAXB) ? MAXB : m_beats + 1;
      if (m_beats == MAXB && others) rel = 1;
`else
      if (rd && others) rel = rel;
`endif
      if (rel) begin
        m_ptr   = (old + 1) % 4;
        m_owner = -1;
        m_beats = 0;
        found   = 0;
        for (int k = 0; k < 4; k++) begin
          c = (m_ptr + k) % 4;
          if (!found && c != old && q[c]) begin
            found = 1; m_owner = c; m_sel = 2'(c);
          end
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic [3:0] q, input logic rd);
    rst = r; req = q; ready = rd;
    @(posedge clk);
    model_step(r, q, rd);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 4'b1111, 1'b1);
      n_checks++;
      if ({gnt, sel, valid} !== 7'b0000_00_0) begin
        n_fail++;
        $display("FAIL reset_hold: gnt=%b sel=%b valid=%b, expected 0000/00/0", gnt, sel, valid);
      end
    end
    cycle(1'b0, 4'b1111, 1'b1);
    n_checks++;
    if ({gnt, sel, valid} !== 7'b0001_00_1) begin
      n_fail++;
      $display("FAIL reset_first_grant: gnt=%b sel=%b valid=%b, expected 0001/00/1", gnt, sel, valid);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] want;
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 4'b1111 & ~(4'b0001 << ((i - 1) % 4)), 1'b1);
      want = 4'b0001 << (i % 4);
      n_checks++;
      if (gnt !== want || valid !== 1'b1 || sel !== 2'(i % 4)) begin
        n_fail++;
        $display("FAIL rotation_%0d: gnt=%b sel=%0d valid=%b, expected gnt=%b sel=%0d valid=1",
                 i, gnt, sel, valid, want, i % 4);
      end
    end
  endtask

  task automatic test_hold();
    bit bad;
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0100, 1'b0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 4'b0100, 1'(i % 2));
      if (gnt !== 4'b0100 || sel !== 2'd2 || valid !== 1'b1) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL hold: gnt=%b sel=%b valid=%b, expected 0100/10/1 throughout", gnt, sel, valid);
    end
  endtask

  task automatic test_priority_skip();
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0001, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    n_checks++;
    if (valid !== 1'b0 || gnt !== 4'b0000 || sel !== 2'd0) begin
      n_fail++;
      $display("FAIL skip_idle: gnt=%b sel=%b valid=%b, expected 0000/00/0", gnt, sel, valid);
    end
    cycle(1'b0, 4'b1001, 1'b1);
    n_checks++;
    if (gnt !== 4'b1000 || sel !== 2'd3 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL skip_ch3_first: gnt=%b sel=%b valid=%b, expected 1000/11/1", gnt, sel, valid);
    end
    cycle(1'b0, 4'b0001, 1'b1);
    n_checks++;
    if (gnt !== 4'b0001 || sel !== 2'd0 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL skip_ch0_next: gnt=%b sel=%b valid=%b, expected 0001/00/1", gnt, sel, valid);
    end
  endtask

  task automatic test_reset_mid_grant();
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0100, 1'b1);
    n_checks++;
    if (gnt !== 4'b0100 || sel !== 2'd2 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_grant: gnt=%b sel=%b valid=%b, expected 0100/10/1", gnt, sel, valid);
    end
    cycle(1'b1, 4'b0100, 1'b1);
    n_checks++;
    if (gnt !== 4'b0000 || sel !== 2'd0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_clear: gnt=%b sel=%b valid=%b, expected 0000/00/0", gnt, sel, valid);
    end
    cycle(1'b0, 4'b0100, 1'b1);
    n_checks++;
    if (gnt !== 4'b0100 || sel !== 2'd2 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_regrant: gnt=%b sel=%b valid=%b, expected 0100/10/1", gnt, sel, valid);
    end
  endtask

`ifdef ARB_MAX_BEATS_EN
  task automatic test_max_beats();
    bit bad;
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0011, 1'b1);
    for (int b = 1; b <= MAXB; b++) begin
      cycle(1'b0, 4'b0011, 1'b1);
      n_checks++;
      if (b < MAXB && gnt !== 4'b0001) begin
        n_fail++;
        $display("FAIL beats_hold_%0d: gnt=%b, expected 0001", b, gnt);
      end else if (b == MAXB && (gnt !== 4'b0010 || valid !== 1'b1)) begin
        n_fail++;
        $display("FAIL beats_release: gnt=%b valid=%b, expected 0010/1", gnt, valid);
      end
    end
    cycle(1'b1, 4'b0000, 1'b0);
    bad = 0;
    for (int i = 0; i < 3 * MAXB; i++) begin
      cycle(1'b0, 4'b0001, 1'b1);
      if (gnt !== 4'b0001 || valid !== 1'b1) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL beats_saturate: gnt=%b valid=%b, expected 0001/1 held", gnt, valid);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] q;
    logic       r;
    q = 4'b0000;
    cycle(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) q = 4'($urandom);
      r = ($urandom_range(0, 59) == 0);
      cycle(r, q, 1'($urandom));
      n_checks++;
      if (gnt !== exp_gnt() || valid !== (m_owner >= 0) || sel !== m_sel) begin
        n_fail++;
        $display("FAIL random_%0d: gnt=%b sel=%0d valid=%b, expected gnt=%b sel=%0d valid=%0d (req=%b)",
                 i, gnt, sel, valid, exp_gnt(), m_sel, m_owner >= 0, q);
      end
      n_checks++;
      if (!$onehot0(gnt) || valid !== (|gnt)) begin
        n_fail++;
        $display("FAIL random_invariant_%0d: gnt=%b valid=%b, expected onehot0 gnt and valid==|gnt",
                 i, gnt, valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_hold();
    test_priority_skip();
    test_reset_mid_grant();
`ifdef ARB_MAX_BEATS_EN
    test_max_beats();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
